// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding a DEPTH-entry prefetch queue.
// Optional macro FETCH_BYPASS_EN lets a fetch into an empty queue appear at the head in the same cycle.
module fetch_unit #(
  parameter int unsigned PC_INIT = 0,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic                    imemREN,
  output logic [AW-1:0]           imemaddr,
  input  logic [DW-1:0]           imemload,
  input  logic                    ihit,
  input  logic                    redirect,
  input  logic [AW-1:0]           redirect_pc,
  input  logic                    halt,
  input  logic                    deq,
  output logic                    valid,
  output logic [DW-1:0]           instr,
  output logic [AW-1:0]           instr_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AW-1:0] fpc;
  logic          halt_q;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [DW-1:0] q_instr [DEPTH];
  logic [AW-1:0] q_pc    [DEPTH];

  logic empty;
  logic push;
  logic bypass;
  logic push_store;
  logic pop_store;

  assign imemaddr = fpc;

  // A bypassed entry consumed in its arrival cycle never occupies a slot.
  always_comb begin
    empty   = (count == '0);
    imemREN = !halt_q && !redirect && (count < FULL);
    push    = imemREN && ihit;
`ifdef FETCH_BYPASS_EN
    bypass  = empty && push;
`else
    bypass  = 1'b0;
`endif
    pop_store  = deq && !empty;
    push_store = push && !(bypass && deq);
    valid      = !empty || bypass;
    instr      = '0;
    instr_pc   = '0;
    if (!empty) begin
      instr    = q_instr[rptr];
      instr_pc = q_pc[rptr];
    end else if (bypass) begin
      instr    = imemload;
      instr_pc = fpc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fpc    <= AW'(PC_INIT);
      count  <= '0;
      rptr   <= '0;
      wptr   <= '0;
      halt_q <= 1'b0;
    end else begin
      if (halt)
        halt_q <= 1'b1;
      if (redirect) begin
        count <= '0;
        rptr  <= '0;
        wptr  <= '0;
        fpc   <= redirect_pc & ~(AW'(3));
      end else begin
        if (push)
          fpc <= fpc + AW'(4);
        if (push_store)
          wptr <= wptr + PW'(1);
        if (pop_store)
          rptr <= rptr + PW'(1);
        count <= count + (PW+1)'(push_store) - (PW+1)'(pop_store);
      end
    end
  end

  // Storage needs no reset; valid masks stale entries.
  always_ff @(posedge CLK) begin
    if (push_store && !RST) begin
      q_instr[wptr] <= imemload;
      q_pc[wptr]    <= fpc;
    end
  end

endmodule
